mc_control_unit: RTL and testbench
==================================

# mc_control_unit

Multi-cycle control sequencer for the MIPS datapath. It replaces single-cycle combinational decode with a state machine that walks each instruction through IF/ID/EXE/MEM/WB. It drives every datapath enable and mux select (PC, IR, register file, ALU, data memory) from the current state plus the opcode held in the IR. It sits inside `CPU` between the instruction register and the datapath, and also exports a retired-instruction count for the bench.

## Interface
Parameters:
- `CNT_W`, 32, width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `op`  in  6  opcode from the IR; stable from ID onward.
- `zero`  in  1  ALU zero flag; sampled combinationally in EXE_BR.
- `PCWre`  out  1  PC load enable.
- `PCSrc`  out  2  next-PC select: 00 PC+4, 01 PC+4+(imm<<2), 10 rs, 11 jump target.
- `IRWre`  out  1  IR load enable.
- `InsMemRW`  out  1  instruction memory read.
- `ExtSel`  out  1  1 sign-extend, 0 zero-extend.
- `ALUSrcA`  out  1  1 selects `sa`.
- `ALUSrcB`  out  1  1 selects the extended immediate.
- `ALUOp`  out  3  000 add, 001 sub, 010 sll, 011 or, 100 and, 101 slt.
- `RegDst`  out  2  00 $31, 01 rt, 10 rd.
- `RegWre`  out  1  register file write enable.
- `WrRegDSrc`  out  1  0 PC+4, 1 DB bus.
- `DBDataSrc`  out  1  0 ALU result, 1 data memory.
- `mRD`, `mWR`  out  1 each  data memory read and write.
- `state`  out  3  current state, for debug.
- `retired`  out  CNT_W  count of completed instructions.

## Operation
- Opcodes:
  - add 000000, sub 000001, addi 000010
  - or 010000, and 010001, ori 010010
  - sll 011000, slt 100110
  - sw 110000, lw 110001
  - beq 110100, bne 110101
  - j 111000, jr 111001, jal 111010
  - halt 111111
- State encodings: IF 000, ID 001, EXE_LS 010, MEM 011, WB_LD 100, EXE_BR 101, EXE_AL 110, WB_AL 111.
- State paths:
  - ALU ops: IF→ID→EXE_AL→WB_AL→IF.
  - beq/bne: IF→ID→EXE_BR→IF.
  - sw: IF→ID→EXE_LS→MEM→IF.
  - lw: IF→ID→EXE_LS→MEM→WB_LD→IF.
  - j/jr/jal: IF→ID→IF.
  - halt: ID self-loop until reset.
  - Unknown opcode: IF→ID→IF as a NOP (PCSrc=00).
- IF: IRWre=1, InsMemRW=1; all other outputs 0.
- PCWre=1 for exactly one cycle, in the final state of each instruction. PCSrc is valid only in that cycle.
  - Branches: PCSrc=01 when taken (beq with zero=1, bne with zero=0), else 00.
  - j: 11. jr: 10.
- EXE_AL / WB_AL:
  - ALUSrcB=1 for addi/ori.
  - ALUSrcA=1 for sll.
  - ExtSel=0 only for ori.
  - RegDst=01 for immediate forms, 10 otherwise.
  - RegWre=1, WrRegDSrc=1, DBDataSrc=0 in WB_AL only.
- EXE_LS: ALUSrcB=1, ExtSel=1, ALUOp=add.
- MEM: mWR=1 for sw, mRD=1 for lw.
- WB_LD: DBDataSrc=1, RegDst=01, RegWre=1, WrRegDSrc=1.
- EXE_BR: ALUOp=sub, ExtSel=1.
- `retired` increments on every cycle with PCWre=1 and wraps modulo 2^CNT_W. Halt never increments it.

## Timing
- The state register is the only sequential state besides `retired`. All control outputs are combinational from `state` and `op` (plus `zero` in EXE_BR).
- Reset asserted, asynchronously: state=IF, retired=0.
  - Outputs immediately take IF decode: IRWre=1, InsMemRW=1, all others 0.
  - An in-flight mWR or RegWre drops without waiting for a clock edge.
- Reset released: the first rising edge latches the IR; the instruction completes 2–5 cycles later, per its path.
- Cycles per instruction: j/jr/jal 2, branch 3, ALU/sw 4, lw 5.
- Reset mid-instruction: the PC is not updated and the partial instruction is discarded.
- `op` changing outside ID..final state is a bench error; the block does not guard against it.

## Configuration
- `MC_JAL_EN` defined: jal finishes in ID with RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11, PCWre=1.
- `MC_JAL_EN` undefined: 111010 decodes as an unknown opcode, i.e. a NOP with RegWre=0.

## Structure
- Shared package `mc_pkg`:
  - opcode constants, state encodings;
  - PCSrc, ALUOp and RegDst encodings.
- One sub-module, `mc_decode`: purely combinational, maps (state, op, zero) to the control outputs.
- The top level holds the state register, the next-state logic and the `retired` counter.

## Test plan
- Reset held low, then released with op=add: state sequence 000,001,110,111,000. PCWre high only in 111. RegWre=1, RegDst=10 in 111. retired=1.
- lw: 5-cycle path. mRD=1 only in MEM, DBDataSrc=1 and RegWre=1 in WB_LD. sw: mWR=1 in MEM, RegWre never 1.
- beq with zero=1 → PCSrc=01 in EXE_BR. beq with zero=0 → PCSrc=00. bne mirrors this. Each takes 3 cycles.
- jal with `MC_JAL_EN` → 2 cycles, RegWre=1, RegDst=00, PCSrc=11. Without the macro → PCSrc=00, RegWre=0.
- halt → state stays 001 for 20 cycles, PCWre=0, retired frozen. Reset low → state 000.
- Reset dropped during MEM of sw: mWR falls within the same cycle, retired=0. Preload retired to 2^32−1, complete one instruction → retired wraps to 0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, states,
// datapath select codes and the bundled control-output struct.
package mc_pkg;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_BNE  = 6'b110101;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_RS     = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RD_RA = 2'b00;
  localparam logic [1:0] RD_RT = 2'b01;
  localparam logic [1:0] RD_RD = 2'b10;

  typedef struct packed {
    logic       pc_wre;
    logic [1:0] pc_src;
    logic       ir_wre;
    logic       ins_mem_rw;
    logic       ext_sel;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] reg_dst;
    logic       reg_wre;
    logic       wr_reg_d_src;
    logic       db_data_src;
    logic       m_rd;
    logic       m_wr;
  } ctrl_t;

  function automatic logic is_alu(input logic [5:0] op);
    return op inside {OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLL, OP_SLT};
  endfunction

  function automatic logic [2:0] alu_fn(input logic [5:0] op);
    case (op)
      OP_SUB:        return ALU_SUB;
      OP_SLL:        return ALU_SLL;
      OP_OR, OP_ORI: return ALU_OR;
      OP_AND:        return ALU_AND;
      OP_SLT:        return ALU_SLT;
      default:       return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational control decode from (state, op, zero).
// MC_JAL_EN: when defined, jal completes in ID and links into $31.
module mc_decode
  import mc_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op,
  input  logic       zero,
  output ctrl_t      ctrl
);

  logic imm;
  assign imm = (op == OP_ADDI) || (op == OP_ORI);

  always_comb begin
    ctrl = '0;
    case (state)
      S_IF: begin
        ctrl.ir_wre     = 1'b1;
        ctrl.ins_mem_rw = 1'b1;
      end
      S_ID: begin
        // Jumps and unknown opcodes retire here; multi-cycle ops and halt do not.
        if (!(is_alu(op) || op inside {OP_SW, OP_LW, OP_BEQ, OP_BNE, OP_HALT}))
          ctrl.pc_wre = 1'b1;
        case (op)
          OP_J:  ctrl.pc_src = PC_JUMP;
          OP_JR: ctrl.pc_src = PC_RS;
`ifdef MC_JAL_EN
          OP_JAL: begin
            ctrl.pc_src       = PC_JUMP;
            ctrl.reg_wre      = 1'b1;
            ctrl.reg_dst      = RD_RA;
            ctrl.wr_reg_d_src = 1'b0;
          end
`endif
          default: ctrl.pc_src = PC_NEXT;
        endcase
      end
      S_EXE_AL, S_WB_AL: begin
        ctrl.alu_src_b = imm;
        ctrl.alu_src_a = (op == OP_SLL);
        ctrl.ext_sel   = (op != OP_ORI);
        ctrl.alu_op    = alu_fn(op);
        ctrl.reg_dst   = imm ? RD_RT : RD_RD;
        if (state == S_WB_AL) begin
          ctrl.reg_wre      = 1'b1;
          ctrl.wr_reg_d_src = 1'b1;
          ctrl.pc_wre       = 1'b1;
        end
      end
      S_EXE_LS: begin
        ctrl.alu_src_b = 1'b1;
        ctrl.ext_sel   = 1'b1;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM: begin
        ctrl.m_wr   = (op == OP_SW);
        ctrl.m_rd   = (op == OP_LW);
        ctrl.pc_wre = (op == OP_SW);
      end
      S_WB_LD: begin
        ctrl.db_data_src  = 1'b1;
        ctrl.reg_dst      = RD_RT;
        ctrl.reg_wre      = 1'b1;
        ctrl.wr_reg_d_src = 1'b1;
        ctrl.pc_wre       = 1'b1;
      end
      S_EXE_BR: begin
        ctrl.alu_op  = ALU_SUB;
        ctrl.ext_sel = 1'b1;
        ctrl.pc_wre  = 1'b1;
        if ((op == OP_BEQ && zero) || (op == OP_BNE && !zero))
          ctrl.pc_src = PC_BRANCH;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control sequencer: state register, next-state logic and
// retired-instruction counter around the mc_decode output decoder.
module mc_control_unit
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic             zero,
  output logic             PCWre,
  output logic [1:0]       PCSrc,
  output logic             IRWre,
  output logic             InsMemRW,
  output logic             ExtSel,
  output logic             ALUSrcA,
  output logic             ALUSrcB,
  output logic [2:0]       ALUOp,
  output logic [1:0]       RegDst,
  output logic             RegWre,
  output logic             WrRegDSrc,
  output logic             DBDataSrc,
  output logic             mRD,
  output logic             mWR,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  state_t state_q, state_d;
  ctrl_t  ctrl;

  mc_decode u_decode (
    .state (state_q),
    .op    (op),
    .zero  (zero),
    .ctrl  (ctrl)
  );

  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= S_IF;
    else        state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        if (is_alu(op))                      state_d = S_EXE_AL;
        else if (op inside {OP_BEQ, OP_BNE}) state_d = S_EXE_BR;
        else if (op inside {OP_SW, OP_LW})   state_d = S_EXE_LS;
        else if (op == OP_HALT)              state_d = S_ID;
        else                                 state_d = S_IF;
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_EXE_LS: state_d = S_MEM;
      S_MEM:    state_d = (op == OP_LW) ? S_WB_LD : S_IF;
      default:  state_d = S_IF;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset)           retired <= '0;
    else if (ctrl.pc_wre) retired <= retired + CNT_W'(1);

  assign state     = state_q;
  assign PCWre     = ctrl.pc_wre;
  assign PCSrc     = ctrl.pc_src;
  assign IRWre     = ctrl.ir_wre;
  assign InsMemRW  = ctrl.ins_mem_rw;
  assign ExtSel    = ctrl.ext_sel;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ALUOp     = ctrl.alu_op;
  assign RegDst    = ctrl.reg_dst;
  assign RegWre    = ctrl.reg_wre;
  assign WrRegDSrc = ctrl.wr_reg_d_src;
  assign DBDataSrc = ctrl.db_data_src;
  assign mRD       = ctrl.m_rd;
  assign mWR       = ctrl.m_wr;

endmodule

// File: tb/tb_mc_control_unit.sv
// Randomized instruction-level bench for mc_control_unit; expectations come
// from per-instruction cycle tables built from the opcode rules.
module tb_mc_control_unit;

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDI = 6'b000010;
  localparam logic [5:0] OR_ = 6'b010000, AND_ = 6'b010001, ORI = 6'b010010;
  localparam logic [5:0] SLL = 6'b011000, SLT = 6'b100110;
  localparam logic [5:0] SW = 6'b110000, LW = 6'b110001;
  localparam logic [5:0] BEQ = 6'b110100, BNE = 6'b110101;
  localparam logic [5:0] J = 6'b111000, JR = 6'b111001, JAL = 6'b111010, HALT = 6'b111111;

  logic clk = 1'b0, reset = 1'b0, zero = 1'b0;
  logic [5:0] op = ADD;
  logic PCWre, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB, RegWre, WrRegDSrc, DBDataSrc, mRD, mWR;
  logic [1:0] PCSrc, RegDst;
  logic [2:0] ALUOp, state;
  logic [31:0] retired;
  logic s_PCWre, s_IRWre, s_InsMemRW, s_ExtSel, s_ALUSrcA, s_ALUSrcB, s_RegWre;
  logic s_WrRegDSrc, s_DBDataSrc, s_mRD, s_mWR;
  logic [1:0] s_PCSrc, s_RegDst;
  logic [2:0] s_ALUOp, s_state, s_retired;

  int checks = 0, errors = 0;
  longint model_ret = 0;

  always #5 clk = ~clk;

  mc_control_unit #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .InsMemRW(InsMemRW), .ExtSel(ExtSel),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegDst(RegDst), .RegWre(RegWre),
    .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc), .mRD(mRD), .mWR(mWR),
    .state(state), .retired(retired)
  );

  // Narrow counter copy so modulo wrap is exercised many times per run.
  mc_control_unit #(.CNT_W(3)) dut_small (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .PCWre(s_PCWre), .PCSrc(s_PCSrc), .IRWre(s_IRWre), .InsMemRW(s_InsMemRW), .ExtSel(s_ExtSel),
    .ALUSrcA(s_ALUSrcA), .ALUSrcB(s_ALUSrcB), .ALUOp(s_ALUOp), .RegDst(s_RegDst), .RegWre(s_RegWre),
    .WrRegDSrc(s_WrRegDSrc), .DBDataSrc(s_DBDataSrc), .mRD(s_mRD), .mWR(s_mWR),
    .state(s_state), .retired(s_retired)
  );

  logic [17:0] obs;
  assign obs = {PCWre, PCSrc, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB, ALUOp,
                RegDst, RegWre, WrRegDSrc, DBDataSrc, mRD, mWR};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_alu_op(input logic [5:0] o);
    return o == ADD || o == SUB || o == ADDI || o == OR_ || o == AND_ || o == ORI || o == SLL || o == SLT;
  endfunction

  function automatic bit is_known(input logic [5:0] o);
    return is_alu_op(o) || o == SW || o == LW || o == BEQ || o == BNE ||
           o == J || o == JR || o == JAL || o == HALT;
  endfunction

  // Cycles from IF to retirement; halt never retires.
  function automatic int cpi(input logic [5:0] o);
    if (o == HALT)               return 0;
    if (is_alu_op(o) || o == SW) return 4;
    if (o == LW)                 return 5;
    if (o == BEQ || o == BNE)    return 3;
    return 2;
  endfunction

  function automatic logic [2:0] st_path(input logic [5:0] o, input int k);
    if (k == 0) return 3'b000;
    if (k == 1) return 3'b001;
    if (is_alu_op(o)) return (k == 2) ? 3'b110 : 3'b111;
    if (o == BEQ || o == BNE) return 3'b101;
    return (k == 2) ? 3'b010 : (k == 3) ? 3'b011 : 3'b100;
  endfunction

  function automatic logic [2:0] alu_code(input logic [5:0] o);
    if (o == SUB) return 3'd1;
    if (o == SLL) return 3'd2;
    if (o == OR_ || o == ORI) return 3'd3;
    if (o == AND_) return 3'd4;
    if (o == SLT) return 3'd5;
    return 3'd0;
  endfunction

  function automatic logic [17:0] exp_ctrl(input logic [5:0] o, input logic z, input int k);
    logic pcw = 0, irw = 0, imr = 0, ext = 0, sa = 0, sb = 0, rw = 0, wrd = 0, dbd = 0, mrd = 0, mwr = 0;
    logic [1:0] pcs = 0, rdst = 0;
    logic [2:0] aop = 0;
    int n = cpi(o);
    if (k == 0) begin
      irw = 1; imr = 1;
    end else begin
      pcw = (k == n - 1);
      if (is_alu_op(o) && k >= 2) begin
        sb = (o == ADDI || o == ORI); sa = (o == SLL); ext = (o != ORI);
        aop = alu_code(o); rdst = sb ? 2'b01 : 2'b10;
        if (k == 3) begin rw = 1; wrd = 1; end
      end else if ((o == SW || o == LW) && k >= 2) begin
        if (k == 2) begin sb = 1; ext = 1; end
        if (k == 3) begin mwr = (o == SW); mrd = (o == LW); end
        if (k == 4) begin dbd = 1; rdst = 2'b01; rw = 1; wrd = 1; end
      end else if ((o == BEQ || o == BNE) && k == 2) begin
        aop = 3'd1; ext = 1;
        pcs = ((o == BEQ && z) || (o == BNE && !z)) ? 2'b01 : 2'b00;
      end else if (n == 2) begin
        if (o == J) pcs = 2'b11;
        else if (o == JR) pcs = 2'b10;
`ifdef MC_JAL_EN
        else if (o == JAL) begin pcs = 2'b11; rw = 1; end
`endif
      end
    end
    return {pcw, pcs, irw, imr, ext, sa, sb, aop, rdst, rw, wrd, dbd, mrd, mwr};
  endfunction

  task automatic do_reset(input logic [5:0] o);
    reset = 1'b0;
    #1;
    model_ret = 0;
    chk("rst_state", state, 3'b000);
    chk("rst_ctrl", obs, exp_ctrl(o, zero, 0));
    chk("rst_ret", retired, 0);
    chk("rst_ret8", s_retired, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_instr(input logic [5:0] o, input int abort_k);
    int n = cpi(o);
    op = o;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      zero = 1'($urandom_range(0, 1));
      #1;
      chk($sformatf("state op=%b k=%0d", o, k), state, st_path(o, k));
      chk($sformatf("ctrl op=%b k=%0d z=%b", o, k, zero), obs, exp_ctrl(o, zero, k));
      if (k == abort_k) begin
        do_reset(o);
        return;
      end
    end
    @(posedge clk); #1;
    model_ret++;
    chk("retired", retired, model_ret[31:0]);
    chk("retired_w3", s_retired, 32'(model_ret % 8));
    chk("back_to_if", state, 3'b000);
  endtask

  task automatic run_halt();
    op = HALT;
    #1;
    chk("halt_if", state, 3'b000);
    @(posedge clk); #1;
    for (int c = 0; c < 20; c++) begin
      zero = 1'($urandom_range(0, 1));
      #1;
      chk("halt_state", state, 3'b001);
      chk("halt_ctrl", obs, exp_ctrl(HALT, zero, 1));
      chk("halt_ret", retired, model_ret[31:0]);
      @(posedge clk); #1;
    end
    do_reset(HALT);
  endtask

  initial begin
    logic [5:0] o;
    logic [5:0] ops [15];
    ops = '{ADD, SUB, ADDI, OR_, AND_, ORI, SLL, SLT, SW, LW, BEQ, BNE, J, JR, JAL};
    #2;
    chk("init_state", state, 3'b000);
    chk("init_ctrl", obs, exp_ctrl(ADD, zero, 0));
    chk("init_ret", retired, 0);
    @(negedge clk);
    reset = 1'b1;

    foreach (ops[i]) run_instr(ops[i], -1);
    run_instr(SW, 3);
    run_halt();
    for (int i = 0; i < 8; i++) run_instr(BEQ, -1);
    for (int i = 0; i < 8; i++) run_instr(BNE, -1);
    run_instr(JAL, -1);

    for (int i = 0; i < 400; i++) begin
      int ab;
      if ($urandom_range(0, 15) == 0) begin
        do o = 6'($urandom); while (is_known(o));
      end else begin
        o = ops[$urandom_range(0, 14)];
      end
      ab = ($urandom_range(0, 19) == 0) ? $urandom_range(1, cpi(o) - 1) : -1;
      run_instr(o, ab);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
